// File: rtl/edge_pkg.sv
// Shared types and constants for the edge-map column writer.
// Pixel binarization lives here so every consumer of the edge map agrees on it.
package edge_pkg;

    localparam int IMG_WIDTH_DEF  = 320;
    localparam int IMG_HEIGHT_DEF = 240;
    localparam int COL_PIXELS     = 10;

    localparam logic [7:0] EDGE_ON  = 8'hFF;
    localparam logic [7:0] EDGE_OFF = 8'h00;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WRITE   = 2'd1,
        ST_ADVANCE = 2'd2
    } writer_state_t;

    function automatic logic [7:0] binarize(input logic [7:0] pix);
        logic [7:0] res;
        if (pix != 8'h00) begin
            res = EDGE_ON;
        end else begin
            res = EDGE_OFF;
        end
        return res;
    endfunction

endpackage

// File: rtl/flex_counter.sv
// Generic up-counter with synchronous clear, wrapping to zero after rollover_val.
// rollover_flag is registered and is high while count_out equals rollover_val.
module flex_counter #(
    parameter int NUM_CNT_BITS = 4
) (
    input  logic                    clk,
    input  logic                    n_rst,
    input  logic                    clear,
    input  logic                    count_enable,
    input  logic [NUM_CNT_BITS-1:0] rollover_val,
    output logic [NUM_CNT_BITS-1:0] count_out,
    output logic                    rollover_flag
);

    logic [NUM_CNT_BITS-1:0] next_count_s;

    // Next count: clear has priority, then wrap or increment on enable.
    always_comb begin
        next_count_s = count_out;
        if (clear) begin
            next_count_s = {NUM_CNT_BITS{1'b0}};
        end else if (count_enable) begin
            if (count_out == rollover_val) begin
                next_count_s = {NUM_CNT_BITS{1'b0}};
            end else begin
                next_count_s = count_out + {{(NUM_CNT_BITS-1){1'b0}}, 1'b1};
            end
        end else begin
            next_count_s = count_out;
        end
    end

    // Count register and its registered terminal flag.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            count_out     <= {NUM_CNT_BITS{1'b0}};
            rollover_flag <= 1'b0;
        end else begin
            count_out     <= next_count_s;
            rollover_flag <= (next_count_s == rollover_val);
        end
    end

endmodule

// File: rtl/edge_writer.sv
// Writes each 10-pixel hysteresis result column, binarized, into the edge-map
// frame buffer over a req/ack byte port while tracking raster position.
module edge_writer
    import edge_pkg::*;
#(
    parameter int IMG_WIDTH  = IMG_WIDTH_DEF,
    parameter int IMG_HEIGHT = IMG_HEIGHT_DEF,
    parameter int ADDR_W     = 17
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              frame_start,
    input  logic              hyst_final,
    input  logic [9:0][7:0]   hyst_out,
    output logic              mem_wr_req,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    input  logic              mem_wr_ack,
    output logic              writer_busy,
    output logic              frame_done,
    output logic              overrun
);

    localparam int XW = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
    localparam int YW = $clog2(IMG_HEIGHT + 1);

    localparam logic [XW-1:0]     X_LAST    = XW'(IMG_WIDTH - 1);
    localparam logic [YW-1:0]     Y_LAST    = YW'(IMG_HEIGHT - COL_PIXELS);
    localparam logic [YW-1:0]     Y_STEP    = YW'(COL_PIXELS);
    localparam logic [ADDR_W-1:0] ROW_STEP  = ADDR_W'(IMG_WIDTH);
    // Jump from the last column of one band to the first column of the next.
    localparam logic [ADDR_W-1:0] BAND_STEP = ADDR_W'((COL_PIXELS - 1) * IMG_WIDTH + 1);
    localparam logic [3:0]        ROW_LAST  = 4'(COL_PIXELS - 1);

    writer_state_t      state_r;
    writer_state_t      next_state_s;
    logic               hyst_final_d_r;
    logic               active_r;
    logic [XW-1:0]      x_r;
    logic [YW-1:0]      y_r;
    logic [ADDR_W-1:0]  base_r;
    logic [9:0][7:0]    buf_r;
    logic [3:0]         row_idx_s;
    logic               last_row_s;
    logic               col_evt_s;
    logic               handshake_s;
    logic               frame_end_s;
    logic               drop_s;
    logic               arm_s;
    logic               capture_s;
    logic               step_s;
    logic               col_end_s;
    logic               advance_s;

    assign col_evt_s   = hyst_final & ~hyst_final_d_r;
    assign handshake_s = mem_wr_req & mem_wr_ack;
    assign frame_end_s = (x_r == X_LAST) && (y_r == Y_LAST);
    assign drop_s      = col_evt_s && (state_r != ST_IDLE);

    flex_counter #(
        .NUM_CNT_BITS (4)
    ) u_row_cnt (
        .clk           (clk),
        .n_rst         (n_rst),
        .clear         (state_r != ST_WRITE),
        .count_enable  (handshake_s),
        .rollover_val  (ROW_LAST),
        .count_out     (row_idx_s),
        .rollover_flag (last_row_s)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // FSM next-state logic; a frame_start in IDLE swallows a coincident column.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (!frame_start && col_evt_s && active_r) begin
                    next_state_s = ST_WRITE;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_WRITE: begin
                if (handshake_s && last_row_s) begin
                    next_state_s = ST_ADVANCE;
                end else begin
                    next_state_s = ST_WRITE;
                end
            end
            ST_ADVANCE: next_state_s = ST_IDLE;
            default:    next_state_s = ST_IDLE;
        endcase
    end

    // FSM output decode into datapath strobes.
    always_comb begin
        arm_s     = 1'b0;
        capture_s = 1'b0;
        step_s    = 1'b0;
        col_end_s = 1'b0;
        advance_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (frame_start) begin
                    arm_s = 1'b1;
                end else if (col_evt_s && active_r) begin
                    capture_s = 1'b1;
                end else begin
                    capture_s = 1'b0;
                end
            end
            ST_WRITE: begin
                if (handshake_s && last_row_s) begin
                    col_end_s = 1'b1;
                end else if (handshake_s) begin
                    step_s = 1'b1;
                end else begin
                    step_s = 1'b0;
                end
            end
            ST_ADVANCE: advance_s = 1'b1;
            default:    advance_s = 1'b0;
        endcase
    end

    // Edge detector and status outputs.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            hyst_final_d_r <= 1'b1;
            mem_wr_req     <= 1'b0;
            writer_busy    <= 1'b0;
            frame_done     <= 1'b0;
            overrun        <= 1'b0;
        end else begin
            hyst_final_d_r <= hyst_final;
            mem_wr_req     <= (next_state_s == ST_WRITE);
            writer_busy    <= (next_state_s != ST_IDLE);
            frame_done     <= col_end_s && frame_end_s;
            if (arm_s) begin
                overrun <= 1'b0;
            end else if (drop_s) begin
                overrun <= 1'b1;
            end
        end
    end

    // Raster position; base_r always equals y*IMG_WIDTH + x without a multiplier.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            active_r <= 1'b0;
            x_r      <= {XW{1'b0}};
            y_r      <= {YW{1'b0}};
            base_r   <= {ADDR_W{1'b0}};
        end else if (arm_s) begin
            active_r <= 1'b1;
            x_r      <= {XW{1'b0}};
            y_r      <= {YW{1'b0}};
            base_r   <= {ADDR_W{1'b0}};
        end else if (advance_s) begin
            if (x_r == X_LAST) begin
                x_r    <= {XW{1'b0}};
                y_r    <= y_r + Y_STEP;
                base_r <= base_r + BAND_STEP;
            end else begin
                x_r    <= x_r + {{(XW-1){1'b0}}, 1'b1};
                base_r <= base_r + {{(ADDR_W-1){1'b0}}, 1'b1};
            end
            if (frame_end_s) begin
                active_r <= 1'b0;
            end
        end
    end

    // Column buffer and write port address/data, stepped one row per accepted write.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            buf_r     <= {10{8'h00}};
            mem_addr  <= {ADDR_W{1'b0}};
            mem_wdata <= 8'h00;
        end else if (capture_s) begin
            buf_r     <= hyst_out;
            mem_addr  <= base_r;
            mem_wdata <= binarize(hyst_out[0]);
        end else if (step_s) begin
            mem_addr  <= mem_addr + ROW_STEP;
            mem_wdata <= binarize(buf_r[row_idx_s + 4'd1]);
        end
    end

endmodule

// File: tb/tb_edge_writer.sv
// Bench for edge_writer: a full-size and a tiny-frame instance share stimulus and
// are checked every cycle against a transaction-level column/raster model.
module tb_edge_writer;

    localparam int LOG_MAX = 8192;

    logic            clk = 1'b0;
    logic            n_rst;
    logic            frame_start;
    logic            hyst_final;
    logic [9:0][7:0] hyst_out;
    logic            mem_wr_ack;

    logic        b_req, b_busy, b_done, b_ovr;
    logic [16:0] b_addr;
    logic [7:0]  b_wdata;
    logic        s_req, s_busy, s_done, s_ovr;
    logic [6:0]  s_addr;
    logic [7:0]  s_wdata;

    logic        d_req  [2];
    logic        d_busy [2];
    logic        d_done [2];
    logic        d_ovr  [2];
    logic [31:0] d_addr [2];
    logic [7:0]  d_data [2];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int ack_mode = 0;

    // behavioural model state
    int mw   [2] = '{320, 4};
    int mh   [2] = '{240, 20};
    int mask [2] = '{(1 << 17) - 1, (1 << 7) - 1};
    int m_x [2], m_y [2], m_base [2], m_idx [2];
    int m_data [2][10];
    bit m_act [2], m_incol [2], m_adv [2], m_done [2], m_ovr [2];
    bit hf_prev;

    // write log built from observed handshakes
    int log_addr [2][LOG_MAX];
    int log_data [2][LOG_MAX];
    int log_n    [2] = '{0, 0};
    int fd_cnt   [2] = '{0, 0};
    bit p_req    [2] = '{1'b0, 1'b0};
    int p_addr   [2];
    int p_data   [2];

    always #5 clk = ~clk;

    edge_writer #(.IMG_WIDTH(320), .IMG_HEIGHT(240), .ADDR_W(17)) u_big (
        .clk(clk), .n_rst(n_rst), .frame_start(frame_start), .hyst_final(hyst_final),
        .hyst_out(hyst_out), .mem_wr_req(b_req), .mem_addr(b_addr), .mem_wdata(b_wdata),
        .mem_wr_ack(mem_wr_ack), .writer_busy(b_busy), .frame_done(b_done), .overrun(b_ovr));

    edge_writer #(.IMG_WIDTH(4), .IMG_HEIGHT(20), .ADDR_W(7)) u_small (
        .clk(clk), .n_rst(n_rst), .frame_start(frame_start), .hyst_final(hyst_final),
        .hyst_out(hyst_out), .mem_wr_req(s_req), .mem_addr(s_addr), .mem_wdata(s_wdata),
        .mem_wr_ack(mem_wr_ack), .writer_busy(s_busy), .frame_done(s_done), .overrun(s_ovr));

    assign d_req[0]  = b_req;   assign d_req[1]  = s_req;
    assign d_busy[0] = b_busy;  assign d_busy[1] = s_busy;
    assign d_done[0] = b_done;  assign d_done[1] = s_done;
    assign d_ovr[0]  = b_ovr;   assign d_ovr[1]  = s_ovr;
    assign d_addr[0] = {15'd0, b_addr};
    assign d_addr[1] = {25'd0, s_addr};
    assign d_data[0] = b_wdata; assign d_data[1] = s_wdata;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_x[k] = 0; m_y[k] = 0; m_base[k] = 0; m_idx[k] = 0;
            m_act[k] = 1'b0; m_incol[k] = 1'b0; m_adv[k] = 1'b0;
            m_done[k] = 1'b0; m_ovr[k] = 1'b0;
        end
        hf_prev = 1'b1;
    endtask

    // One clock edge of the writer for instance k, in column/raster terms.
    task automatic model_step(input int k, input bit evt);
        m_done[k] = 1'b0;
        if (!m_incol[k] && !m_adv[k]) begin
            if (frame_start) begin
                m_x[k] = 0; m_y[k] = 0; m_act[k] = 1'b1; m_ovr[k] = 1'b0;
            end else if (evt && m_act[k]) begin
                m_base[k]  = m_y[k] * mw[k] + m_x[k];
                m_idx[k]   = 0;
                m_incol[k] = 1'b1;
                for (int i = 0; i < 10; i++) m_data[k][i] = (hyst_out[i] != 8'h00) ? 255 : 0;
            end
        end else begin
            if (evt) m_ovr[k] = 1'b1;
            if (m_adv[k]) begin
                m_adv[k] = 1'b0;
            end else if (mem_wr_ack) begin
                m_idx[k]++;
                if (m_idx[k] == 10) begin
                    m_incol[k] = 1'b0;
                    m_adv[k]   = 1'b1;
                    if (m_x[k] == mw[k] - 1 && m_y[k] + 10 == mh[k]) begin
                        m_done[k] = 1'b1;
                        m_act[k]  = 1'b0;
                    end
                    if (m_x[k] == mw[k] - 1) begin
                        m_x[k] = 0; m_y[k] += 10;
                    end else begin
                        m_x[k]++;
                    end
                end
            end
        end
    endtask

    // Model update on the rising edge, comparison on the falling edge.
    initial begin : compare_proc
        bit evt;
        model_reset();
        forever begin
            @(posedge clk);
            for (int k = 0; k < 2; k++) begin
                if (n_rst && p_req[k] && mem_wr_ack) begin
                    if (log_n[k] < LOG_MAX) begin
                        log_addr[k][log_n[k]] = p_addr[k];
                        log_data[k][log_n[k]] = p_data[k];
                    end
                    log_n[k]++;
                end
            end
            if (!n_rst) begin
                model_reset();
            end else begin
                evt = hyst_final && !hf_prev;
                for (int k = 0; k < 2; k++) model_step(k, evt);
                hf_prev = hyst_final;
            end
            @(negedge clk);
            if (!n_rst) model_reset();
            for (int k = 0; k < 2; k++) begin
                check($sformatf("req[%0d]", k), int'(d_req[k]), int'(m_incol[k]));
                check($sformatf("busy[%0d]", k), int'(d_busy[k]), int'(m_incol[k] || m_adv[k]));
                check($sformatf("frame_done[%0d]", k), int'(d_done[k]), int'(m_done[k]));
                check($sformatf("overrun[%0d]", k), int'(d_ovr[k]), int'(m_ovr[k]));
                if (m_incol[k]) begin
                    check($sformatf("addr[%0d]", k), int'(d_addr[k]),
                          (m_base[k] + m_idx[k] * mw[k]) & mask[k]);
                    check($sformatf("wdata[%0d]", k), int'(d_data[k]), m_data[k][m_idx[k]]);
                end
                if (d_done[k]) fd_cnt[k]++;
                p_req[k]  = d_req[k];
                p_addr[k] = int'(d_addr[k]);
                p_data[k] = int'(d_data[k]);
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
        cyc++;
        case (ack_mode)
            0:       mem_wr_ack = 1'b1;
            1:       mem_wr_ack = ((cyc % 3) == 0);
            default: mem_wr_ack = 1'($urandom_range(0, 1));
        endcase
    endtask

    function automatic logic [7:0] rnd_pix();
        logic [7:0] v;
        if ($urandom_range(0, 2) == 0) v = 8'h00;
        else v = 8'($urandom_range(1, 255));
        return v;
    endfunction

    task automatic rnd_column_data();
        for (int i = 0; i < 10; i++) hyst_out[i] = rnd_pix();
    endtask

    task automatic pulse_frame_start();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
    endtask

    task automatic wait_idle(input int limit);
        int n = 0;
        while ((b_busy || s_busy) && n < limit) begin
            tick();
            n++;
        end
        if (n >= limit) check("idle_timeout", int'(b_busy || s_busy), 0);
    endtask

    task automatic column();
        hyst_final = 1'b0;
        tick();
        hyst_final = 1'b1;
        tick();
        wait_idle(400);
    endtask

    initial begin : stimulus
        int m0, m1, fd0, busy_cnt, m_after;
        n_rst = 1'b0; frame_start = 1'b0; hyst_final = 1'b1;
        hyst_out = {10{8'h00}}; mem_wr_ack = 1'b1;
        repeat (3) tick();
        check("rst_req", int'(b_req), 0);
        check("rst_busy", int'(b_busy), 0);
        check("rst_addr", int'(b_addr), 0);
        check("rst_done", int'(b_done), 0);
        check("rst_ovr", int'(b_ovr), 0);
        n_rst = 1'b1;
        tick();

        // basic column, ack tied high
        pulse_frame_start();
        for (int i = 0; i < 10; i++) hyst_out[i] = 8'(i * 20);
        m0 = log_n[0];
        hyst_final = 1'b0; tick();
        hyst_final = 1'b1; tick();
        busy_cnt = 0;
        for (int n = 0; n < 16; n++) begin
            if (b_busy) busy_cnt++;
            tick();
        end
        check("t1_busy_cycles", busy_cnt, 11);
        check("t1_nwrites", log_n[0] - m0, 10);
        check("t1_addr0", log_addr[0][m0], 0);
        check("t1_addr1", log_addr[0][m0 + 1], 320);
        check("t1_addr9", log_addr[0][m0 + 9], 2880);
        check("t1_data0", log_data[0][m0], 0);
        check("t1_data1", log_data[0][m0 + 1], 255);
        check("t1_data9", log_data[0][m0 + 9], 255);
        m0 = log_n[0];
        column();
        check("t1_next_base", log_addr[0][m0], 1);

        // slow ack: every third cycle
        ack_mode = 1;
        rnd_column_data();
        m0 = log_n[0];
        column();
        check("t2_nwrites", log_n[0] - m0, 10);
        check("t2_last_addr", log_addr[0][m0 + 9], 2 + 9 * 320);
        ack_mode = 0;

        // full row on the big frame, full frame on the small one
        pulse_frame_start();
        m0 = log_n[0]; m1 = log_n[1]; fd0 = fd_cnt[1];
        ack_mode = 2;
        for (int c = 0; c < 321; c++) begin
            rnd_column_data();
            column();
        end
        check("t3_nwrites", log_n[0] - m0, 3210);
        check("t3_col321_base", log_addr[0][m0 + 3200], 3200);
        check("t4_small_nwrites", log_n[1] - m1, 80);
        check("t4_small_last_addr", log_addr[1][m1 + 79], 79);
        check("t4_frame_done_pulses", fd_cnt[1] - fd0, 1);

        // second rise while writing
        ack_mode = 0;
        pulse_frame_start();
        rnd_column_data();
        m0 = log_n[0];
        hyst_final = 1'b0; tick();
        hyst_final = 1'b1; tick();
        hyst_final = 1'b0; tick(); tick();
        hyst_final = 1'b1; tick();
        wait_idle(100);
        check("t5_overrun", int'(b_ovr), 1);
        check("t5_nwrites", log_n[0] - m0, 10);
        pulse_frame_start();
        check("t5_overrun_cleared", int'(b_ovr), 0);

        // reset in the middle of a column, hyst_final held high across release
        rnd_column_data();
        hyst_final = 1'b0; tick();
        hyst_final = 1'b1; tick();
        repeat (4) tick();
        n_rst = 1'b0;
        #1;
        check("t6_req_drop", int'(b_req), 0);
        check("t6_busy_drop", int'(b_busy), 0);
        m_after = log_n[0];
        repeat (3) tick();
        n_rst = 1'b1;
        repeat (20) tick();
        check("t6_no_writes", log_n[0] - m_after, 0);
        column();
        check("t6_inactive_no_writes", log_n[0] - m_after, 0);

        // randomized traffic with stray frame_start and hyst_final toggles
        pulse_frame_start();
        ack_mode = 2;
        for (int n = 0; n < 800; n++) begin
            if ($urandom_range(0, 3) == 0) hyst_final = ~hyst_final;
            frame_start = ($urandom_range(0, 63) == 0);
            rnd_column_data();
            tick();
        end
        frame_start = 1'b0;
        wait_idle(200);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin : watchdog
        #3000000;
        $display("FAIL watchdog: got no finish want finish by time limit");
        $fatal(1);
    end

endmodule
